// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: UART register map indices and the bridge access FSM states.
package uart_bridge_pkg;
    localparam int REG_RX     = 0;
    localparam int REG_TX     = 1;
    localparam int REG_STATUS = 2;
    localparam int REG_CTRL   = 3;
    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;
endpackage

// File: rtl/ubb_fifo.sv
// ubb_fifo: synchronous first-word fall-through FIFO; push and pop in one cycle are both honoured.
module ubb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign w_pop   = i_pop && !o_empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/uart_byte_bridge.sv
// uart_byte_bridge: drains UART RX bytes on interrupt into a FIFO stream and
// writes a tx byte stream to the UART TX register, with ack timeouts.
module uart_byte_bridge
    import uart_bridge_pkg::*;
#(
    parameter int RX_DEPTH    = 4,
    parameter int RX_REG      = REG_RX,
    parameter int TX_REG      = REG_TX,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       aresetn,
    input  logic       uart_interrupt,
    output logic [3:0] uart_rcen,
    input  logic       uart_rack,
    input  logic [7:0] uart_rdata,
    output logic [3:0] uart_wcen,
    input  logic       uart_wack,
    output logic [7:0] uart_wdata,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_overflow,
    output logic       bus_error
);
    localparam int PW = $clog2(RX_DEPTH) + 1;
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;
    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_pend;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_wdata;
    logic          w_full;
    logic          w_empty;
    logic          w_rd_elig;
    logic          w_ack;
    logic          w_timeout;
    logic          w_done;
    logic          w_rd_done;
    // an interrupt arriving this cycle already makes a read eligible, so it wins over a waiting tx byte
    assign w_rd_elig = (r_pend != '0 || uart_interrupt) && !w_full;
    assign w_ack     = (r_state == ST_RD && uart_rack) || (r_state == ST_WR && uart_wack);
    assign w_timeout = r_state != ST_IDLE && !w_ack && r_tmo == TW'(ACK_TIMEOUT - 1);
    assign w_done    = w_ack || w_timeout;
    assign w_rd_done = r_state == ST_RD && w_done;
    assign uart_rcen  = (r_state == ST_RD) ? 4'b1 << RX_REG : 4'b0;
    assign uart_wcen  = (r_state == ST_WR) ? 4'b1 << TX_REG : 4'b0;
    assign uart_wdata = r_wdata;
    assign tx_ready   = r_state == ST_WR && uart_wack;
    assign rx_valid   = !w_empty;
    always_comb begin
        w_next = r_state;
        if (r_state == ST_IDLE)
            w_next = w_rd_elig ? ST_RD : (tx_valid ? ST_WR : ST_IDLE);
        else if (w_done)
            w_next = ST_IDLE;
    end
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_pend      <= '0;
            r_tmo       <= '0;
            r_wdata     <= '0;
            rx_overflow <= 1'b0;
            bus_error   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tmo   <= (r_state == ST_IDLE) ? '0 : r_tmo + 1'b1;
            if (r_state == ST_IDLE && w_next == ST_WR) r_wdata <= tx_data;
            if (uart_interrupt && !w_rd_done && r_pend == PW'(RX_DEPTH))
                rx_overflow <= 1'b1;
            else
                r_pend <= r_pend + PW'(uart_interrupt) - PW'(w_rd_done);
            if (w_timeout) bus_error <= 1'b1;
        end
    end
    ubb_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .i_push  (r_state == ST_RD && uart_rack),
        .i_data  (uart_rdata),
        .i_pop   (rx_ready),
        .o_data  (rx_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_uart_byte_bridge.sv
// tb_uart_byte_bridge: directed scenarios plus randomized traffic against a
// transaction-level model (byte queues, outstanding-interrupt count, sticky flags).
module tb_uart_byte_bridge;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    logic       clk = 1'b0;
    logic       aresetn;
    logic       uart_interrupt;
    logic [3:0] uart_rcen;
    logic       uart_rack;
    logic [7:0] uart_rdata;
    logic [3:0] uart_wcen;
    logic       uart_wack;
    logic [7:0] uart_wdata;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_overflow;
    logic       bus_error;

    uart_byte_bridge dut (
        .clk(clk), .aresetn(aresetn), .uart_interrupt(uart_interrupt),
        .uart_rcen(uart_rcen), .uart_rack(uart_rack), .uart_rdata(uart_rdata),
        .uart_wcen(uart_wcen), .uart_wack(uart_wack), .uart_wdata(uart_wdata),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_overflow(rx_overflow), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // stimulus/model shared state
    logic [7:0] rd_src[$];
    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];
    logic [7:0] exp_tx[$];
    int acc_log[$];
    int rd_lat = 1;
    int wr_lat = 1;
    bit rnd_mode = 0;
    int rd_cnt = 0, pop_cnt = 0, tx_acc_cnt = 0;
    int last_rd_len = 0, last_wr_len = 0, last_txr_len = 0;
    int m_pend = 0, m_fifo = 0;
    bit m_ovf = 0, m_err = 0;
    int v_excl = 0, v_stab = 0, v_gap = 0, v_fifo = 0, v_flag = 0, v_tmo = 0, v_txr = 0, v_spur = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // UART register slave: acks after a latency counted in cycles of enable
    initial begin
        int rd_n, wr_n, rl, wl;
        logic [7:0] b;
        uart_rack = 0; uart_rdata = 0; uart_wack = 0;
        rd_n = 0; wr_n = 0; rl = 1; wl = 1;
        forever begin
            @(negedge clk);
            if (uart_rcen != 4'd0) begin
                rd_n++;
                if (rd_n == 1) rl = rnd_mode ? (($urandom_range(0, 15) == 0) ? 99 : int'($urandom_range(1, 4))) : rd_lat;
                if (!uart_rack && rd_n > rl) begin
                    b = (rd_src.size() != 0) ? rd_src.pop_front() : 8'($urandom);
                    uart_rdata = b;
                    uart_rack = 1;
                    exp_rx.push_back(b);
                end
            end else begin
                rd_n = 0;
                uart_rack = 0;
            end
            if (uart_wcen != 4'd0) begin
                wr_n++;
                if (wr_n == 1) wl = rnd_mode ? (($urandom_range(0, 15) == 0) ? 99 : int'($urandom_range(1, 4))) : wr_lat;
                if (!uart_wack && wr_n > wl) begin
                    uart_wack = 1;
                    chk("tx_byte", {24'd0, uart_wdata}, (exp_tx.size() != 0) ? {24'd0, exp_tx.pop_front()} : 32'hdead);
                end
            end else begin
                wr_n = 0;
                uart_wack = 0;
            end
        end
    end

    // tx source: offers queued bytes, holds each until accepted
    initial begin
        int seen;
        seen = 0; tx_valid = 0; tx_data = 0;
        forever begin
            @(negedge clk);
            if (tx_acc_cnt != seen) begin
                seen = tx_acc_cnt;
                tx_valid = 0;
            end
            if (!tx_valid && tx_q.size() != 0) begin
                tx_data = tx_q.pop_front();
                tx_valid = 1;
                exp_tx.push_back(tx_data);
            end
        end
    end

    // monitor: samples 1ns before each rising edge and advances the model
    initial begin
        int rd_cyc, wr_cyc, txr_run;
        bit p_rcen, p_wcen, p_done, rd_done, wr_done, en;
        logic [7:0] p_wdata;
        rd_cyc = 0; wr_cyc = 0; txr_run = 0;
        p_rcen = 0; p_wcen = 0; p_done = 0; p_wdata = 0;
        forever begin
            @(negedge clk); #4;
            if (aresetn !== 1'b1) begin
                m_pend = 0; m_fifo = 0; m_ovf = 0; m_err = 0; exp_rx.delete();
                rd_cyc = 0; wr_cyc = 0; txr_run = 0;
                p_rcen = 0; p_wcen = 0; p_done = 0;
                continue;
            end
            if (rx_overflow !== m_ovf || bus_error !== m_err) v_flag++;
            if (rx_valid !== (m_fifo != 0)) v_fifo++;
            if (uart_rcen != 0 && m_fifo == DEPTH) v_fifo++;
            if (!(uart_rcen inside {4'b0000, 4'b0001}) || !(uart_wcen inside {4'b0000, 4'b0010}) ||
                (uart_rcen != 0 && uart_wcen != 0)) v_excl++;
            en = uart_rcen != 0 || uart_wcen != 0;
            if (p_done && en) v_gap++;
            if (uart_wcen != 0 && p_wcen && uart_wdata !== p_wdata) v_stab++;
            if (tx_ready !== (uart_wcen != 0 && uart_wack)) v_txr++;
            if (uart_rcen != 0 && !p_rcen) acc_log.push_back(1);
            if (uart_wcen != 0 && !p_wcen) acc_log.push_back(2);
            rd_cyc = (uart_rcen != 0) ? rd_cyc + 1 : 0;
            wr_cyc = (uart_wcen != 0) ? wr_cyc + 1 : 0;
            if (rd_cyc > TMO || wr_cyc > TMO) v_tmo++;
            rd_done = uart_rcen != 0 && (uart_rack || rd_cyc == TMO);
            wr_done = uart_wcen != 0 && (uart_wack || wr_cyc == TMO);
            if (rd_done) last_rd_len = rd_cyc;
            if (wr_done) last_wr_len = wr_cyc;
            if ((rd_done && !uart_rack) || (wr_done && !uart_wack)) m_err = 1;
            if (rd_done && m_pend == 0) v_spur++;
            if (rx_valid && rx_ready) begin
                pop_cnt++;
                chk("rx_pop", {24'd0, rx_data}, (exp_rx.size() != 0) ? {24'd0, exp_rx.pop_front()} : 32'hdead);
            end
            if (uart_rcen != 0 && uart_rack) rd_cnt++;
            m_fifo += int'(uart_rcen != 0 && uart_rack) - int'(rx_valid && rx_ready);
            if (uart_interrupt && !rd_done && m_pend == DEPTH) m_ovf = 1;
            else m_pend += int'(uart_interrupt) - int'(rd_done);
            if (tx_ready) begin
                tx_acc_cnt++;
                txr_run++;
            end else if (txr_run != 0) begin
                last_txr_len = txr_run;
                txr_run = 0;
            end
            p_rcen = uart_rcen != 0; p_wcen = uart_wcen != 0; p_wdata = uart_wdata;
            p_done = rd_done || wr_done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic pulse_irq(input int gap);
        uart_interrupt = 1; tick(1); uart_interrupt = 0; tick(gap);
    endtask

    initial begin
        int n0, p0;
        bit quiet;
        aresetn = 0; uart_interrupt = 0; rx_ready = 0;
        tick(3);
        aresetn = 1;
        chk("rst_rcen", uart_rcen, 0);
        chk("rst_wcen", uart_wcen, 0);
        chk("rst_wdata", uart_wdata, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_overflow", rx_overflow, 0);
        chk("rst_bus_error", bus_error, 0);

        // single read, ack one cycle after rcen
        rd_lat = 1; rd_src.push_back(8'h5A);
        pulse_irq(0);
        for (int i = 0; i < 40 && !rx_valid; i++) tick(1);
        chk("t1_valid", rx_valid, 1);
        chk("t1_data", rx_data, 8'h5A);
        chk("t1_rcen_len", last_rd_len, 2);
        rx_ready = 1; tick(1); rx_ready = 0;
        chk("t1_drained", rx_valid, 0);

        // fill FIFO, 5th interrupt waits until there is room
        foreach (rd_src[i]) rd_src.delete(i);
        rd_src = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        n0 = rd_cnt; p0 = pop_cnt;
        repeat (5) pulse_irq(2);
        tick(30);
        chk("t2_reads_full", rd_cnt - n0, 4);
        chk("t2_head", rx_data, 8'hA1);
        chk("t2_blocked", uart_rcen, 0);
        rx_ready = 1;
        for (int i = 0; i < 80 && pop_cnt - p0 < 5; i++) tick(1);
        rx_ready = 0;
        chk("t2_pops", pop_cnt - p0, 5);
        chk("t2_no_overflow", rx_overflow, 0);

        // saturate pending with FIFO full
        n0 = rd_cnt;
        repeat (4) pulse_irq(2);
        tick(30);
        chk("t3_full", rd_cnt - n0, 4);
        uart_interrupt = 1; tick(6); uart_interrupt = 0; tick(2);
        chk("t3_overflow", rx_overflow, 1);
        n0 = rd_cnt;
        rx_ready = 1;
        tick(120);
        chk("t3_saturated_reads", rd_cnt - n0, 4);
        chk("t3_drained", rx_valid, 0);

        // slow write ack
        wr_lat = 3; n0 = tx_acc_cnt;
        tx_q.push_back(8'hC3);
        for (int i = 0; i < 20 && uart_wcen == 0; i++) tick(1);
        tick(1);
        chk("t4_wcen", uart_wcen, 4'b0010);
        chk("t4_wdata", uart_wdata, 8'hC3);
        for (int i = 0; i < 40 && tx_acc_cnt == n0; i++) tick(1);
        tick(2);
        chk("t4_accepted", tx_acc_cnt - n0, 1);
        chk("t4_wcen_len", last_wr_len, 4);
        chk("t4_tx_ready_len", last_txr_len, 1);

        // read wins over write offered the same cycle
        wr_lat = 1; acc_log.delete();
        @(posedge clk); #1;
        tx_q.push_back(8'h96);
        @(negedge clk);
        uart_interrupt = 1; tick(1); uart_interrupt = 0;
        tick(20);
        chk("t5_two_accesses", acc_log.size(), 2);
        chk("t5_read_first", (acc_log.size() > 0) ? acc_log[0] : 0, 1);
        chk("t5_write_second", (acc_log.size() > 1) ? acc_log[1] : 0, 2);

        // read timeout, then reset mid-read
        rd_lat = 99;
        pulse_irq(0);
        for (int i = 0; i < 40 && uart_rcen == 0; i++) tick(1);
        for (int i = 0; i < 40 && uart_rcen != 0; i++) tick(1);
        chk("t6_rcen_len", last_rd_len, 16);
        chk("t6_bus_error", bus_error, 1);
        pulse_irq(5);
        chk("t6_mid_read", uart_rcen, 4'b0001);
        aresetn = 0; tick(1);
        chk("t6_rst_rcen", uart_rcen, 0);
        chk("t6_rst_wdata", uart_wdata, 0);
        chk("t6_rst_rx_valid", rx_valid, 0);
        chk("t6_rst_tx_ready", tx_ready, 0);
        chk("t6_rst_overflow", rx_overflow, 0);
        chk("t6_rst_bus_error", bus_error, 0);
        aresetn = 1; rd_lat = 1;
        tick(30);
        chk("t6_no_retry", uart_rcen, 0);

        // randomized traffic
        rnd_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            uart_interrupt = $urandom_range(0, 5) == 0;
            rx_ready = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 9) == 0 && tx_q.size() < 3) tx_q.push_back(8'($urandom));
            tick(1);
        end
        uart_interrupt = 0; rx_ready = 1;
        quiet = 0;
        for (int i = 0; i < 1000 && !quiet; i++) begin
            tick(1);
            quiet = m_pend == 0 && exp_rx.size() == 0 && tx_q.size() == 0 && !tx_valid &&
                    uart_rcen == 0 && uart_wcen == 0;
        end
        chk("rnd_quiesced", quiet, 1);
        chk("rnd_pending", m_pend, 0);
        chk("rnd_rx_left", exp_rx.size(), 0);
        chk("rnd_tx_left", exp_tx.size(), 0);
        chk("enable_encoding", v_excl, 0);
        chk("wdata_stable", v_stab, 0);
        chk("idle_gap", v_gap, 0);
        chk("fifo_state", v_fifo, 0);
        chk("sticky_flags", v_flag, 0);
        chk("timeout_len", v_tmo, 0);
        chk("tx_ready_pulse", v_txr, 0);
        chk("spurious_read", v_spur, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
